dice_pool_roller: RTL and testbench
===================================

// Module: dice_pool_roller
// PURPOSE
//  Initiator side of the dice_roller roll/rolled_number interface. On a start
//  request it issues NUM_DICE single-cycle roll pulses to a dice_roller, samples
//  each result after a fixed latency and range-checks it. It accumulates a sum,
//  min and max and flags out-of-range samples. Sits between game/control logic
//  and the dice_roller instance.
// PARAMETERS
//  ROLL_LATENCY  1   cycles from roll_out high to rolled_number_in valid (>=1)
//  CNT_W         4   width of num_dice; pools of 0..2^CNT_W-1 dice
//  SUM_W         12  width of total; must hold (2^CNT_W-1)*20
// PORTS
//  clk              in   1      single clock, all logic on rising edge
//  rst              in   1      synchronous, active-high reset
//  start            in   1      request a pool roll; sampled only in IDLE
//  die_select       in   2      00=d4 01=d6 10=d8 11=d20; latched on accepted start
//  num_dice         in   CNT_W  dice in pool; latched on accepted start
//  busy             out  1      high from the cycle after an accepted start until done
//  done             out  1      one-cycle pulse: total/min/max/err_count are final
//  total            out  SUM_W  sum of in-range samples
//  min_roll         out  8      smallest in-range sample (0 if none)
//  max_roll         out  8      largest in-range sample (0 if none)
//  err_count        out  CNT_W  number of out-of-range samples in this pool
//  roll_out         out  1      roll pulse to the dice_roller
//  die_select_out   out  2      die type to the dice_roller (latched value)
//  rolled_number_in in   8      result from the dice_roller
// BEHAVIOUR
//  Reset: state IDLE; busy, done, roll_out = 0; total, min_roll, max_roll,
//   err_count = 0; die_select_out = 0; internal counters = 0. Reset mid-pool
//   aborts it with no done pulse; roll_out drops in the next cycle.
//  FSM: IDLE -> ROLL -> WAIT -> SAMPLE -> (ROLL | DONE) -> IDLE.
//   IDLE: start=1 latches die_select and num_dice, clears total, min_roll,
//    max_roll and err_count, and goes to ROLL. If num_dice=0, go to DONE instead.
//   ROLL: roll_out=1 for exactly this cycle, then WAIT.
//   WAIT: hold for ROLL_LATENCY-1 cycles (0 when ROLL_LATENCY=1), then SAMPLE.
//   SAMPLE: capture rolled_number_in. If the dice remaining after this one > 0,
//    go to ROLL; else go to DONE.
//   DONE: done=1 for one cycle, busy=0, then IDLE.
//  Timing: start is sampled at edge 0. Die k has roll_out high in cycle
//   1+(k-1)*(ROLL_LATENCY+1). It is sampled at the end of cycle
//   k*(ROLL_LATENCY+1). done is high in cycle N*(ROLL_LATENCY+1)+1.
//   For num_dice=0, done is high in cycle 1.
//  Range check: legal range is 1..F, with F = 4/6/8/20 from the latched die.
//   - In range: add to total (zero-extended to SUM_W, no wrap by sizing).
//     Update min_roll/max_roll; the first in-range sample sets both.
//   - Out of range: err_count saturates at 2^CNT_W-1; sample is not accumulated.
//  start while busy or in DONE: ignored, never queued.
//  start in the cycle after DONE (back in IDLE): accepted normally.
//  die_select/num_dice changes while busy: no effect.
//  Outputs hold their final values after done until the next accepted start clears them.
//  die_select_out updates on an accepted start and is stable across every roll_out pulse.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0; state IDLE; no roll_out.
//  2. d6, num_dice=3, ROLL_LATENCY=1, model returns 2,6,5 -> roll_out in
//     cycles 1,3,5; done in cycle 7; total=13, min=2, max=6, err_count=0.
//  3. d4, num_dice=2, model returns 0 then 9 -> done in cycle 5; total=0,
//     min=max=0, err_count=2.
//  4. num_dice=0 -> done in cycle 1 with no roll_out; start pulsed while busy
//     in test 2 -> exactly 3 roll_out pulses.
//  5. d20, num_dice=15, model always returns 20 -> total=300 with no overflow;
//     then ROLL_LATENCY=3, num_dice=2 -> roll_out in cycles 1 and 5, done in cycle 9.
//  6. rst asserted mid-pool -> no done pulse, outputs 0; the next start runs a clean pool.

Source files
------------

// File: rtl/dice_pool_roller_if.sv
// ---------------------------------------------------------------------------
// Module  : dice_pool_roller_if
// Brief   : Control/result bus plus dice_roller link for dice_pool_roller.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface dice_pool_roller_if #(
  parameter int CNT_W = 4,
  parameter int SUM_W = 12
) ();
  logic             start;
  logic [1:0]       die_select;
  logic [CNT_W-1:0] num_dice;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] total;
  logic [7:0]       min_roll;
  logic [7:0]       max_roll;
  logic [CNT_W-1:0] err_count;
  logic             roll_out;
  logic [1:0]       die_select_out;
  logic [7:0]       rolled_number_in;

  modport slave (
    input  start, die_select, num_dice, rolled_number_in,
    output busy, done, total, min_roll, max_roll, err_count,
           roll_out, die_select_out
  );

  modport master (
    output start, die_select, num_dice, rolled_number_in,
    input  busy, done, total, min_roll, max_roll, err_count,
           roll_out, die_select_out
  );
endinterface

`default_nettype wire

// File: rtl/dice_pool_roller.sv
// ---------------------------------------------------------------------------
// Module  : dice_pool_roller
// Brief   : Rolls a pool of dice through a dice_roller; accumulates sum/min/max.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dice_pool_roller #(
  parameter int ROLL_LATENCY = 1,
  parameter int CNT_W        = 4,
  parameter int SUM_W        = 12
) (
  input  logic                clk,
  input  logic                rst,
  dice_pool_roller_if.slave   bus
);

  localparam int c_WAIT_W = (ROLL_LATENCY > 1) ? $clog2(ROLL_LATENCY + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
    c_WAIT_W'((ROLL_LATENCY > 1) ? (ROLL_LATENCY - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROLL   = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]    r_left;
  logic [1:0]          r_die;
  logic [SUM_W-1:0]    r_total;
  logic [7:0]          r_min;
  logic [7:0]          r_max;
  logic [CNT_W-1:0]    r_err;
  logic [7:0]          w_face;
  logic                w_in_range;
  logic                w_roll;
  logic                w_busy;
  logic                w_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_roll = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (bus.num_dice == '0) ? S_DONE : S_ROLL;
      end
      S_ROLL: begin
        w_roll = 1'b1;
        w_busy = 1'b1;
        w_next = (ROLL_LATENCY > 1) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_wait == c_WAIT_LAST) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_busy = 1'b1;
        w_next = (r_left == CNT_W'(1)) ? S_DONE : S_ROLL;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_face = 8'd20;
    case (r_die)
      2'b00:   w_face = 8'd4;
      2'b01:   w_face = 8'd6;
      2'b10:   w_face = 8'd8;
      default: w_face = 8'd20;
    endcase
  end

  assign w_in_range = (bus.rolled_number_in != 8'd0) && (bus.rolled_number_in <= w_face);

  // r_min == 0 marks "no in-range sample yet": legal samples are never 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait  <= '0;
      r_left  <= '0;
      r_die   <= '0;
      r_total <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_die   <= bus.die_select;
            r_left  <= bus.num_dice;
            r_total <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_err   <= '0;
          end
        end
        S_ROLL: r_wait <= '0;
        S_WAIT: r_wait <= r_wait + 1'b1;
        S_SAMPLE: begin
          r_left <= r_left - 1'b1;
          if (w_in_range) begin
            r_total <= r_total + SUM_W'(bus.rolled_number_in);
            if (r_min == 8'd0) begin
              r_min <= bus.rolled_number_in;
              r_max <= bus.rolled_number_in;
            end else begin
              if (bus.rolled_number_in < r_min) r_min <= bus.rolled_number_in;
              if (bus.rolled_number_in > r_max) r_max <= bus.rolled_number_in;
            end
          end else if (r_err != '1) begin
            r_err <= r_err + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = w_busy;
  assign bus.done           = w_done;
  assign bus.roll_out       = w_roll;
  assign bus.total          = r_total;
  assign bus.min_roll       = r_min;
  assign bus.max_roll       = r_max;
  assign bus.err_count      = r_err;
  assign bus.die_select_out = r_die;

endmodule

`default_nettype wire

// File: tb/tb_dice_pool_roller.sv
// ---------------------------------------------------------------------------
// Module  : tb_dice_pool_roller
// Brief   : Directed self-checking bench for dice_pool_roller (latency 1 and 3).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

`define CHK(tag, obs, exp) begin \
  n_chk++; \
  assert ((obs) === (exp)) else begin \
    n_fail++; \
    $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
  end \
end

module tb_dice_pool_roller;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dice_pool_roller_if #(.CNT_W(4), .SUM_W(12)) b0 ();
  dice_pool_roller_if #(.CNT_W(4), .SUM_W(12)) b1 ();

  dice_pool_roller #(.ROLL_LATENCY(1), .CNT_W(4), .SUM_W(12)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  dice_pool_roller #(.ROLL_LATENCY(3), .CNT_W(4), .SUM_W(12)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  logic [7:0] vals [0:15];
  logic       use_c;
  logic [7:0] cval;
  int         sel;

  wire        w_roll = (sel == 1) ? b1.roll_out : b0.roll_out;
  wire        w_done = (sel == 1) ? b1.done     : b0.done;
  wire        w_busy = (sel == 1) ? b1.busy     : b0.busy;
  wire [1:0]  w_dso  = (sel == 1) ? b1.die_select_out : b0.die_select_out;

  int          rolls, done_cyc, dones, busy_n, dso_bad;
  logic [63:0] roll_mask;

  task automatic drive_start(input logic s, input logic [1:0] die, input logic [3:0] n);
    if (sel == 1) begin
      b1.start = s; b1.die_select = die; b1.num_dice = n;
    end else begin
      b0.start = s; b0.die_select = die; b0.num_dice = n;
    end
  endtask

  // Start at the next falling edge (cycle 0), then observe cycles 1.. at each
  // falling edge, acting as the dice_roller model whenever roll_out is seen.
  task automatic run_pool(input logic [1:0] die, input logic [3:0] n, input int pulse_cyc);
    int k;
    k = 0;
    rolls = 0; roll_mask = '0; done_cyc = -1; dones = 0; busy_n = 0; dso_bad = 0;
    @(negedge clk);
    drive_start(1'b1, die, n);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      drive_start(c == pulse_cyc, ~die, ~n);
      if (w_busy) busy_n++;
      if (w_roll) begin
        rolls++;
        roll_mask[c] = 1'b1;
        if (w_dso !== die) dso_bad++;
        if (use_c) begin
          b0.rolled_number_in = cval; b1.rolled_number_in = cval;
        end else begin
          b0.rolled_number_in = vals[k]; b1.rolled_number_in = vals[k];
        end
        if (k < 15) k++;
      end
      if (w_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0) break;
    end
    drive_start(1'b0, die, n);
  endtask

  initial begin
    sel = 0; use_c = 1'b0; cval = 8'd0;
    for (int i = 0; i < 16; i++) vals[i] = 8'd0;
    b0.start = 1'b0; b0.die_select = 2'b00; b0.num_dice = 4'd0; b0.rolled_number_in = 8'd0;
    b1.start = 1'b0; b1.die_select = 2'b00; b1.num_dice = 4'd0; b1.rolled_number_in = 8'd0;

    // reset
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    `CHK("rst_busy",  b0.busy, 1'b0)
    `CHK("rst_done",  b0.done, 1'b0)
    `CHK("rst_roll",  b0.roll_out, 1'b0)
    `CHK("rst_total", b0.total, 12'd0)
    `CHK("rst_min",   b0.min_roll, 8'd0)
    `CHK("rst_max",   b0.max_roll, 8'd0)
    `CHK("rst_err",   b0.err_count, 4'd0)
    `CHK("rst_dso",   b0.die_select_out, 2'd0)
    `CHK("rst_roll1", b1.roll_out, 1'b0)
    rst = 1'b0;

    // d6 x3, samples 2,6,5, start pulsed while busy
    vals[0] = 8'd2; vals[1] = 8'd6; vals[2] = 8'd5;
    run_pool(2'b01, 4'd3, 3);
    `CHK("t2_rolls", rolls, 3)
    `CHK("t2_mask",  roll_mask, 64'h2A)
    `CHK("t2_done",  done_cyc, 7)
    `CHK("t2_busy",  busy_n, 6)
    `CHK("t2_dso",   dso_bad, 0)
    `CHK("t2_total", b0.total, 12'd13)
    `CHK("t2_min",   b0.min_roll, 8'd2)
    `CHK("t2_max",   b0.max_roll, 8'd6)
    `CHK("t2_err",   b0.err_count, 4'd0)

    // d4 x2, samples 0 and 9 both out of range; started the cycle after done
    vals[0] = 8'd0; vals[1] = 8'd9;
    run_pool(2'b00, 4'd2, 0);
    `CHK("t3_done",  done_cyc, 5)
    `CHK("t3_total", b0.total, 12'd0)
    `CHK("t3_min",   b0.min_roll, 8'd0)
    `CHK("t3_max",   b0.max_roll, 8'd0)
    `CHK("t3_err",   b0.err_count, 4'd2)
    @(negedge clk);
    `CHK("t3_hold",  b0.err_count, 4'd2)

    // empty pool
    run_pool(2'b10, 4'd0, 0);
    `CHK("t4_done",  done_cyc, 1)
    `CHK("t4_rolls", rolls, 0)
    `CHK("t4_err",   b0.err_count, 4'd0)
    `CHK("t4_dso",   b0.die_select_out, 2'b10)

    // d20 x15, all 20
    use_c = 1'b1; cval = 8'd20;
    run_pool(2'b11, 4'd15, 0);
    use_c = 1'b0;
    `CHK("t5_rolls", rolls, 15)
    `CHK("t5_done",  done_cyc, 31)
    `CHK("t5_total", b0.total, 12'd300)
    `CHK("t5_min",   b0.min_roll, 8'd20)
    `CHK("t5_max",   b0.max_roll, 8'd20)

    // latency 3, d8 x2, samples 3,8
    sel = 1;
    vals[0] = 8'd3; vals[1] = 8'd8;
    run_pool(2'b10, 4'd2, 0);
    `CHK("t5l_mask",  roll_mask, 64'h22)
    `CHK("t5l_done",  done_cyc, 9)
    `CHK("t5l_busy",  busy_n, 8)
    `CHK("t5l_total", b1.total, 12'd11)
    `CHK("t5l_min",   b1.min_roll, 8'd3)
    `CHK("t5l_max",   b1.max_roll, 8'd8)
    sel = 0;

    // reset mid-pool, then a clean pool
    vals[0] = 8'd4; vals[1] = 8'd4; vals[2] = 8'd4;
    @(negedge clk);
    drive_start(1'b1, 2'b01, 4'd3);
    @(negedge clk);
    drive_start(1'b0, 2'b01, 4'd3);
    b0.rolled_number_in = 8'd4;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    `CHK("t6_roll",  b0.roll_out, 1'b0)
    `CHK("t6_busy",  b0.busy, 1'b0)
    `CHK("t6_total", b0.total, 12'd0)
    `CHK("t6_min",   b0.min_roll, 8'd0)
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b0.done || b0.roll_out) dones++;
    end
    `CHK("t6_quiet", dones, 0)
    run_pool(2'b01, 4'd1, 0);
    `CHK("t6_done",  done_cyc, 3)
    `CHK("t6_total2", b0.total, 12'd4)
    `CHK("t6_max2",  b0.max_roll, 8'd4)

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
